// File: rtl/snake_step_ctrl_if.sv
// snake_step_ctrl_if: heading type plus the control/status bundle between the direction FSM and the step scheduler
//   direction (in)  : heading from the direction FSM
//   restart   (in)  : one-cycle request to return to IDLE
//   head_x/y  (out) : head cell
//   step      (out) : one-cycle pulse when the head moved
//   running   (out) : high in RUN
//   game_over (out) : high in OVER
//   move_cnt  (out) : successful steps since start, saturating
package game_pkg;
  typedef enum logic [2:0] {WAIT, RIGHT, DOWN, LEFT, UP} directions;
endpackage

interface snake_step_ctrl_if #(parameter int XW = 5, parameter int YW = 5);
  import game_pkg::*;
  directions     direction;
  logic          restart;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          step;
  logic          running;
  logic          game_over;
  logic [15:0]   move_cnt;
  modport master (output direction, restart, input head_x, head_y, step, running, game_over, move_cnt);
  modport slave  (input direction, restart, output head_x, head_y, step, running, game_over, move_cnt);
endinterface

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: turns the current heading into timed grid steps of the snake head with wall collision
//   clk   : VGA clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of snake_step_ctrl_if (direction/restart in; head, step, running, game_over, move_cnt out)
module snake_step_ctrl
  import game_pkg::*;
#(
  parameter int GRID_W      = 32,
  parameter int GRID_H      = 24,
  parameter int START_X     = 16,
  parameter int START_Y     = 12,
  parameter int MOVE_PERIOD = 6_500_000
) (
  input logic              clk,
  input logic              rst_n,
  snake_step_ctrl_if.slave bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int TW = $clog2(MOVE_PERIOD);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;
  state_t        r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic          r_step, w_step;
  logic [15:0]   r_cnt, w_cnt;
  logic [XW:0]   w_cx;
  logic [YW:0]   w_cy;
  logic          w_term, w_move, w_ok;
  assign w_term = (r_state == S_RUN) && (r_timer == TW'(MOVE_PERIOD - 1));
  assign w_move = bus.direction != WAIT;
  // one extra bit so that stepping off cell 0 wraps to a large value and fails the range check
  assign w_cx = bus.direction == RIGHT ? {1'b0, r_x} + (XW+1)'(1) :
                bus.direction == LEFT  ? {1'b0, r_x} - (XW+1)'(1) : {1'b0, r_x};
  assign w_cy = bus.direction == DOWN  ? {1'b0, r_y} + (YW+1)'(1) :
                bus.direction == UP    ? {1'b0, r_y} - (YW+1)'(1) : {1'b0, r_y};
  assign w_ok = (w_cx < (XW+1)'(GRID_W)) && (w_cy < (YW+1)'(GRID_H));
  always_comb begin
    w_state = r_state;
    w_timer = '0;
    w_x     = r_x;
    w_y     = r_y;
    w_step  = 1'b0;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: w_state = w_move ? S_RUN : S_IDLE;
      S_RUN: begin
        w_timer = w_term ? '0 : r_timer + TW'(1);
        if (w_term && w_move) begin
          if (w_ok) begin
            w_x    = w_cx[XW-1:0];
            w_y    = w_cy[YW-1:0];
            w_step = 1'b1;
            w_cnt  = r_cnt + {15'd0, r_cnt != 16'hFFFF};
          end else
            w_state = S_OVER;
        end
      end
      default: ;
    endcase
    // restart overrides everything above, including a coincident terminal count
    if (bus.restart) begin
      w_state = S_IDLE;
      w_timer = '0;
      w_x     = XW'(START_X);
      w_y     = YW'(START_Y);
      w_step  = 1'b0;
      w_cnt   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_x     <= XW'(START_X);
      r_y     <= YW'(START_Y);
      r_step  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_x     <= w_x;
      r_y     <= w_y;
      r_step  <= w_step;
      r_cnt   <= w_cnt;
    end
  end
  assign bus.head_x    = r_x;
  assign bus.head_y    = r_y;
  assign bus.step      = r_step;
  assign bus.running   = r_state == S_RUN;
  assign bus.game_over = r_state == S_OVER;
  assign bus.move_cnt  = r_cnt;
endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: directed table-driven check of snake_step_ctrl on an 8x6 grid, period 4, start (4,3)
module tb_snake_step_ctrl;
  import game_pkg::*;
  typedef struct {
    int        rep;
    logic      rn;
    logic      rs;
    directions d;
    int        x;
    int        y;
    logic      s;
    logic      r;
    logic      o;
    int        c;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t v[$];
  snake_step_ctrl_if #(.XW(3), .YW(3)) bus ();
  snake_step_ctrl #(.GRID_W(8), .GRID_H(6), .START_X(4), .START_Y(3), .MOVE_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void add(int rep, logic rn, logic rs, directions d, int x, int y,
                              logic s, logic r, logic o, int c);
    vec_t e;
    e.rep = rep; e.rn = rn; e.rs = rs; e.d = d;
    e.x = x; e.y = y; e.s = s; e.r = r; e.o = o; e.c = c;
    v.push_back(e);
  endfunction
  task automatic chk(string nm, int x, int y, logic s, logic r, logic o, int c);
    checks++;
    if (int'(bus.head_x) != x || int'(bus.head_y) != y || bus.step !== s ||
        bus.running !== r || bus.game_over !== o || int'(bus.move_cnt) != c) begin
      failures++;
      $display("FAIL %s: got x=%0d y=%0d step=%b run=%b over=%b cnt=%0d, want x=%0d y=%0d step=%b run=%b over=%b cnt=%0d",
               nm, bus.head_x, bus.head_y, bus.step, bus.running, bus.game_over, bus.move_cnt,
               x, y, s, r, o, c);
    end
  endtask
  task automatic cyc(logic rn, logic rs, directions d);
    rst_n = rn;
    bus.restart = rs;
    bus.direction = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.direction = WAIT;
    bus.restart = 1'b0;
    add(1,  0, 0, WAIT,  4, 3, 0, 0, 0, 0);
    add(20, 1, 0, WAIT,  4, 3, 0, 0, 0, 0);
    add(1,  1, 0, RIGHT, 4, 3, 0, 1, 0, 0);
    add(3,  1, 0, RIGHT, 4, 3, 0, 1, 0, 0);
    add(1,  1, 0, RIGHT, 5, 3, 1, 1, 0, 1);
    add(3,  1, 0, RIGHT, 5, 3, 0, 1, 0, 1);
    add(1,  1, 0, RIGHT, 6, 3, 1, 1, 0, 2);
    add(3,  1, 0, RIGHT, 6, 3, 0, 1, 0, 2);
    add(1,  1, 0, RIGHT, 7, 3, 1, 1, 0, 3);
    add(3,  1, 0, RIGHT, 7, 3, 0, 1, 0, 3);
    add(1,  1, 0, RIGHT, 7, 3, 0, 0, 1, 3);
    add(6,  1, 0, LEFT,  7, 3, 0, 0, 1, 3);
    add(1,  1, 1, WAIT,  4, 3, 0, 0, 0, 0);
    add(2,  1, 0, WAIT,  4, 3, 0, 0, 0, 0);
    add(1,  1, 0, UP,    4, 3, 0, 1, 0, 0);
    add(3,  1, 0, UP,    4, 3, 0, 1, 0, 0);
    add(1,  1, 0, UP,    4, 2, 1, 1, 0, 1);
    add(3,  1, 0, UP,    4, 2, 0, 1, 0, 1);
    add(1,  1, 0, UP,    4, 1, 1, 1, 0, 2);
    add(3,  1, 0, UP,    4, 1, 0, 1, 0, 2);
    add(1,  1, 0, UP,    4, 0, 1, 1, 0, 3);
    add(3,  1, 0, UP,    4, 0, 0, 1, 0, 3);
    add(1,  1, 0, UP,    4, 0, 0, 0, 1, 3);
    add(1,  1, 1, UP,    4, 3, 0, 0, 0, 0);
    add(1,  1, 0, LEFT,  4, 3, 0, 1, 0, 0);
    add(3,  1, 0, LEFT,  4, 3, 0, 1, 0, 0);
    add(1,  1, 0, LEFT,  3, 3, 1, 1, 0, 1);
    add(3,  1, 0, LEFT,  3, 3, 0, 1, 0, 1);
    add(1,  1, 0, LEFT,  2, 3, 1, 1, 0, 2);
    add(3,  1, 0, LEFT,  2, 3, 0, 1, 0, 2);
    add(1,  1, 0, LEFT,  1, 3, 1, 1, 0, 3);
    add(3,  1, 0, LEFT,  1, 3, 0, 1, 0, 3);
    add(1,  1, 0, LEFT,  0, 3, 1, 1, 0, 4);
    add(3,  1, 0, LEFT,  0, 3, 0, 1, 0, 4);
    add(1,  1, 0, LEFT,  0, 3, 0, 0, 1, 4);
    add(1,  1, 1, WAIT,  4, 3, 0, 0, 0, 0);
    add(1,  1, 0, RIGHT, 4, 3, 0, 1, 0, 0);
    add(1,  1, 0, RIGHT, 4, 3, 0, 1, 0, 0);
    add(1,  1, 0, DOWN,  4, 3, 0, 1, 0, 0);
    add(1,  1, 0, RIGHT, 4, 3, 0, 1, 0, 0);
    add(1,  1, 0, RIGHT, 5, 3, 1, 1, 0, 1);
    add(4,  1, 0, WAIT,  5, 3, 0, 1, 0, 1);
    add(3,  1, 0, DOWN,  5, 3, 0, 1, 0, 1);
    add(1,  1, 0, DOWN,  5, 4, 1, 1, 0, 2);
    add(3,  1, 0, RIGHT, 5, 4, 0, 1, 0, 2);
    add(1,  1, 1, RIGHT, 4, 3, 0, 0, 0, 0);
    add(1,  1, 0, WAIT,  4, 3, 0, 0, 0, 0);
    foreach (v[i])
      for (int k = 0; k < v[i].rep; k++) begin
        cyc(v[i].rn, v[i].rs, v[i].d);
        chk($sformatf("row%0d.%0d", i, k), v[i].x, v[i].y, v[i].s, v[i].r, v[i].o, v[i].c);
      end
    cyc(1, 0, RIGHT);
    chk("rst_seq_enter", 4, 3, 0, 1, 0, 0);
    repeat (3) cyc(1, 0, RIGHT);
    chk("rst_seq_pre", 4, 3, 0, 1, 0, 0);
    cyc(1, 0, RIGHT);
    chk("rst_seq_step", 5, 3, 1, 1, 0, 1);
    repeat (2) cyc(1, 0, RIGHT);
    chk("rst_seq_mid", 5, 3, 0, 1, 0, 1);
    cyc(0, 1, RIGHT);
    chk("rst_seq_reset", 4, 3, 0, 0, 0, 0);
    cyc(1, 0, WAIT);
    chk("rst_seq_idle", 4, 3, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Movement scheduler for the snake game: turns the `directions` value from the mouse-driven direction FSM into timed grid steps of the snake head.
- Owns the game run state (IDLE/RUN/OVER) and the move-period timer.
- Advances the head one cell per period, detects wall collision and counts moves.
- Sits between the direction FSM and the snake body/draw logic in the VGA clock domain.

Parameters:
- GRID_W, 32, grid width in cells
- GRID_H, 24, grid height in cells
- START_X, 16, head column after reset/restart
- START_Y, 12, head row after reset/restart
- MOVE_PERIOD, 6_500_000, clk cycles per step (about 10 Hz at 65 MHz); must be ≥ 2

Ports:
- clk  in  1  system (VGA) clock
- rst_n  in  1  synchronous active-low reset
- direction  in  directions (game_pkg)  current heading: WAIT/RIGHT/DOWN/LEFT/UP
- restart  in  1  single-cycle request to return to IDLE
- head_x  out  $clog2(GRID_W)  head column
- head_y  out  $clog2(GRID_H)  head row
- step  out  1  one-cycle pulse when the head has moved
- running  out  1  high in RUN
- game_over  out  1  high in OVER
- move_cnt  out  16  successful steps since start, saturating

Behaviour:
- Reset, sampled on posedge clk while rst_n=0:
  - state=IDLE, head=(START_X,START_Y), timer=0, move_cnt=0.
  - step, running and game_over are all 0.
- All outputs are registered. The head/move_cnt update and the step pulse appear in the same cycle, one cycle after the terminal timer count.
- IDLE:
  - timer held at 0; head held at the start cell.
  - direction≠WAIT → RUN next cycle, timer starting at 0.
  - direction=WAIT → stay in IDLE.
- RUN:
  - timer counts 0..MOVE_PERIOD-1 and wraps to 0.
  - At timer=MOVE_PERIOD-1, direction is sampled that cycle and the next cell is computed:
    - RIGHT: x+1.
    - LEFT: x-1.
    - DOWN: y+1.
    - UP: y-1.
    - WAIT: no move, no step, move_cnt unchanged, stay in RUN.
  - Bounds check is done in widths one bit wider than head_x/head_y so that underflow from 0 is detected.
  - Result in range [0,GRID_W-1]×[0,GRID_H-1]: head updated, step=1 for one cycle, move_cnt+1, saturating at 16'hFFFF.
  - Result out of range: head unchanged, no step, move_cnt unchanged, → OVER.
  - Direction changes between terminal counts are ignored; only the value at the terminal cycle counts.
- OVER:
  - game_over=1; head and move_cnt frozen; timer held at 0.
  - direction input ignored.
- restart=1 in any state → IDLE next cycle: head=start cell, move_cnt=0, timer=0, step=0.
  - restart has priority over a coincident terminal count: no step, no collision.
- running=1 only in RUN; game_over=1 only in OVER; the two are never high together.
- rst_n=0 mid-step forces the reset values on the next edge with no step pulse; rst_n has priority over restart.
- No step pulse is produced in IDLE or OVER.

Test Plan (MOVE_PERIOD=4, GRID 8×6, START (4,3)):
- Reset then direction=WAIT for 20 cycles → IDLE held, head=(4,3), step never 1, running=0.
- direction=RIGHT from IDLE → running=1 next cycle; steps 4 cycles apart; head (5,3) then (6,3) then (7,3); move_cnt=3.
- Continue RIGHT at x=7 → at the next terminal count game_over=1, head stays (7,3), no step, move_cnt stays 3; then restart pulse → IDLE, head=(4,3), move_cnt=0.
- direction=UP from (4,3) → y goes 2,1,0; at the 4th terminal count (y would go to -1) → OVER. Checks underflow detection.
- Switch RIGHT→DOWN at timer=1, then back to RIGHT at timer=2 → only RIGHT (the value at the terminal cycle) is applied: head (5,3).
- restart and terminal count in the same cycle → IDLE, no step. Separately, rst_n=0 mid-RUN → all outputs return to reset values next edge.
